fir_4mac_seq: RTL and testbench
===============================

FIR_4MAC_SEQ -- requirements
Module: fir_4mac_seq

Interface
REQ-001 Parameter FILTERBITWIDTH, default 20, width of mux data input and of dout.
REQ-002 Parameter COEFBITWIDTH, default 16, width of each signed coefficient.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one 4-tap MAC pass; sampled only in IDLE.
REQ-006 data_sel  input  FILTERBITWIDTH  signed sample returned by the upstream 4:1 mux for the current mux_sel.
REQ-007 coef0..coef3  input  COEFBITWIDTH each  signed coefficients; coefN pairs with mux_sel==N; held static during a pass.
REQ-008 mux_sel  output  2  registered select driven to the 4:1 mux.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 dout  output  FILTERBITWIDTH  signed filter result, held until next result.
REQ-011 dout_valid  output  1  one-cycle pulse when dout updates.
REQ-012 overrun  output  1  sticky flag: start asserted while busy.

Function
REQ-013 FSM states: IDLE, RUN; IDLE->RUN on start==1, RUN->IDLE after phase 3.
REQ-014 On IDLE->RUN edge: mux_sel<=0, accumulator<=0, busy<=1.
REQ-015 In RUN, each cycle: acc <= acc + data_sel*coef[mux_sel] (signed), mux_sel increments 0,1,2,3.
REQ-016 Product width FILTERBITWIDTH+COEFBITWIDTH; accumulator width FILTERBITWIDTH+COEFBITWIDTH+2; no internal overflow possible.
REQ-017 Final result = (acc + last product) arithmetic-shifted right by COEFBITWIDTH-1 (floor, no rounding), then sized per REQ-026/027.
REQ-018 On edge closing phase 3: dout<=result, dout_valid<=1, mux_sel<=0, busy<=0, state<=IDLE.
REQ-019 Latency: start high at edge k -> dout_valid high in the cycle after edge k+4; throughput one result per 5 cycles.
REQ-020 start while busy is ignored (pass continues unaffected) and sets overrun; overrun clears only on reset.
REQ-021 start in the cycle dout_valid is high is accepted (state is IDLE).
REQ-022 mux_sel is 0 whenever state is IDLE; dout_valid is 0 except the single result cycle.

Reset
REQ-023 rst_n low asynchronously forces state IDLE, mux_sel 0, busy 0, dout 0, dout_valid 0, overrun 0, accumulator 0.
REQ-024 Reset mid-pass aborts the pass; no dout_valid issued for it; first start after release begins a fresh pass.
REQ-025 Outputs are stable at reset values from the first edge after rst_n deasserts until start.

Configuration
REQ-026 Macro FIR_MAC_SAT_EN defined: shifted result saturates to [-2^(FILTERBITWIDTH-1), 2^(FILTERBITWIDTH-1)-1].
REQ-027 Macro FIR_MAC_SAT_EN undefined: shifted result truncated to its low FILTERBITWIDTH bits (two's-complement wrap).

Structure
REQ-028 Shared package fir_pkg holds the FSM state typedef (IDLE, RUN), NUM_TAPS=4 and default width constants.
REQ-029 One sub-module fir_mac_sat performs the shift and the saturate/truncate sizing; the FSM, counter and accumulator stay in the top.
REQ-030 Bench instantiates fir_4mac_seq with the existing 4:1 mux in the loop: mux_sel -> mux, mux output -> data_sel.

Verification
REQ-031 Mux inputs 100,200,300,400; coef0..3=16'h4000; start pulse -> mux_sel sequence 0,1,2,3; dout=500, dout_valid 1 cycle, 5 cycles after start.
REQ-032 All mux inputs -100, coefs 16'h4000 -> dout=-200 (20'hFFF38).
REQ-033 All mux inputs 20'h7FFFF, coefs 16'h7FFF -> with FIR_MAC_SAT_EN dout=20'h7FFFF; without it dout = low 20 bits of floor(4*524287*32767/32768).
REQ-034 start held high 12 cycles -> results at cycles 5 and 10 only, overrun=1; start sampled in the dout_valid cycle begins next pass.
REQ-035 rst_n pulled low during phase 2 -> all outputs to reset values immediately, no dout_valid; following start gives correct 500 (REQ-031 data).

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FSM state type and default widths for the 4-tap
//               sequential FIR MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_TAPS            = 4;
    localparam int FILTERBITWIDTH_DEF  = 20;
    localparam int COEFBITWIDTH_DEF    = 16;

endpackage
`default_nettype wire

// File: rtl/fir_4mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_4mac_seq_if
// Description : Control, mux and result bus of the sequential FIR MAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_4mac_seq_if #(
    parameter int FILTERBITWIDTH = fir_pkg::FILTERBITWIDTH_DEF,
    parameter int COEFBITWIDTH   = fir_pkg::COEFBITWIDTH_DEF
);
    logic                             start;
    logic signed [FILTERBITWIDTH-1:0] data_sel;
    logic signed [COEFBITWIDTH-1:0]   coef0;
    logic signed [COEFBITWIDTH-1:0]   coef1;
    logic signed [COEFBITWIDTH-1:0]   coef2;
    logic signed [COEFBITWIDTH-1:0]   coef3;
    logic [1:0]                       mux_sel;
    logic                             busy;
    logic signed [FILTERBITWIDTH-1:0] dout;
    logic                             dout_valid;
    logic                             overrun;

    modport master (
        output start, data_sel, coef0, coef1, coef2, coef3,
        input  mux_sel, busy, dout, dout_valid, overrun
    );

    modport slave (
        input  start, data_sel, coef0, coef1, coef2, coef3,
        output mux_sel, busy, dout, dout_valid, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sat.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sat
// Description : Scales the MAC sum down by COEFBITWIDTH-1 (floor) and sizes it
//               to FILTERBITWIDTH. FIR_MAC_SAT_EN selects saturation,
//               otherwise two's-complement wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sat #(
    parameter int FILTERBITWIDTH = 20,
    parameter int COEFBITWIDTH   = 16
) (
    input  wire logic signed [FILTERBITWIDTH+COEFBITWIDTH+1:0] i_acc,
    output logic signed [FILTERBITWIDTH-1:0]                   o_result
);
    localparam int c_acc_w = FILTERBITWIDTH + COEFBITWIDTH + 2;

    logic signed [c_acc_w-1:0] w_shifted;

    assign w_shifted = i_acc >>> (COEFBITWIDTH - 1);

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [c_acc_w-1:0] c_max =
        {{(c_acc_w-FILTERBITWIDTH+1){1'b0}}, {(FILTERBITWIDTH-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_min =
        {{(c_acc_w-FILTERBITWIDTH+1){1'b1}}, {(FILTERBITWIDTH-1){1'b0}}};

    always_comb begin
        o_result = w_shifted[FILTERBITWIDTH-1:0];
        if (w_shifted > c_max) begin
            o_result = c_max[FILTERBITWIDTH-1:0];
        end else if (w_shifted < c_min) begin
            o_result = c_min[FILTERBITWIDTH-1:0];
        end
    end
`else
    // Upper bits are deliberately discarded: wrap-around sizing.
    logic w_unused;
    assign w_unused = ^w_shifted[c_acc_w-1:FILTERBITWIDTH];
    assign o_result = w_shifted[FILTERBITWIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/fir_4mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : fir_4mac_seq
// Description : 4-tap FIR using one MAC, time-multiplexed over an external
//               4:1 sample mux. Optional macro: FIR_MAC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_4mac_seq
    import fir_pkg::*;
#(
    parameter int FILTERBITWIDTH = FILTERBITWIDTH_DEF,
    parameter int COEFBITWIDTH   = COEFBITWIDTH_DEF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fir_4mac_seq_if.slave bus
);
    localparam int         c_prod_w     = FILTERBITWIDTH + COEFBITWIDTH;
    localparam int         c_acc_w      = c_prod_w + 2;
    localparam logic [1:0] c_last_phase = 2'(NUM_TAPS - 1);

    state_t                           r_state,      w_state_nxt;
    logic [1:0]                       r_mux_sel,    w_mux_sel_nxt;
    logic signed [c_acc_w-1:0]        r_acc,        w_acc_nxt;
    logic signed [FILTERBITWIDTH-1:0] r_dout,       w_dout_nxt;
    logic                             r_dout_valid, w_dout_valid_nxt;
    logic                             r_overrun,    w_overrun_nxt;

    logic signed [COEFBITWIDTH-1:0]   w_coef;
    logic signed [c_prod_w-1:0]       w_prod;
    logic signed [c_acc_w-1:0]        w_sum;
    logic signed [FILTERBITWIDTH-1:0] w_result;

    always_comb begin
        w_coef = bus.coef0;
        case (r_mux_sel)
            2'd0:    w_coef = bus.coef0;
            2'd1:    w_coef = bus.coef1;
            2'd2:    w_coef = bus.coef2;
            default: w_coef = bus.coef3;
        endcase
    end

    assign w_prod = bus.data_sel * w_coef;
    assign w_sum  = r_acc + {{2{w_prod[c_prod_w-1]}}, w_prod};

    fir_mac_sat #(
        .FILTERBITWIDTH (FILTERBITWIDTH),
        .COEFBITWIDTH   (COEFBITWIDTH)
    ) u_mac_sat (
        .i_acc    (w_sum),
        .o_result (w_result)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_mux_sel_nxt    = r_mux_sel;
        w_acc_nxt        = r_acc;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;
        w_overrun_nxt    = r_overrun;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = RUN;
                    w_mux_sel_nxt = 2'd0;
                    w_acc_nxt     = '0;
                end
            end
            default: begin
                // A start during a pass is dropped but remembered.
                if (bus.start) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_mux_sel == c_last_phase) begin
                    w_dout_nxt       = w_result;
                    w_dout_valid_nxt = 1'b1;
                    w_mux_sel_nxt    = 2'd0;
                    w_state_nxt      = IDLE;
                end else begin
                    w_acc_nxt     = w_sum;
                    w_mux_sel_nxt = r_mux_sel + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mux_sel    <= 2'd0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mux_sel    <= w_mux_sel_nxt;
            r_acc        <= w_acc_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign bus.mux_sel    = r_mux_sel;
    assign bus.busy       = (r_state == RUN);
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_4mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_4mac_seq
// Description : Self-checking bench for fir_4mac_seq with a 4:1 sample mux
//               in the loop. Honours FIR_MAC_SAT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_4mac_seq;
    localparam int FW = 20;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_4mac_seq_if #(.FILTERBITWIDTH(FW), .COEFBITWIDTH(CW)) bus ();

    logic signed [FW-1:0] mux_in [4];
    logic signed [CW-1:0] cf     [4];

    assign bus.data_sel = mux_in[bus.mux_sel];
    assign bus.coef0    = cf[0];
    assign bus.coef1    = cf[1];
    assign bus.coef2    = cf[2];
    assign bus.coef3    = cf[3];

    fir_4mac_seq #(.FILTERBITWIDTH(FW), .COEFBITWIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string                name;
        logic signed [FW-1:0] x [4];
        logic signed [CW-1:0] c [4];
        logic signed [FW-1:0] exp;
    } vec_t;

    vec_t tbl [6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer dot product, floor-divided by 2^(CW-1).
    function automatic logic signed [FW-1:0] model_result();
        longint sum = 0;
        longint q;
        for (int i = 0; i < 4; i++) sum += longint'(mux_in[i]) * longint'(cf[i]);
        q = sum >>> (CW - 1);
`ifdef FIR_MAC_SAT_EN
        if (q > 524287) q = 524287;
        else if (q < -524288) q = -524288;
`endif
        return q[FW-1:0];
    endfunction

    task automatic run_pass(input string name, input logic signed [FW-1:0] exp);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({name, " mux_sel"}, bus.mux_sel, i);
            check({name, " busy"}, bus.busy, 1);
            check({name, " early valid"}, bus.dout_valid, 0);
            tick();
        end
        check({name, " valid"}, bus.dout_valid, 1);
        check({name, " dout"}, bus.dout, exp);
        check({name, " busy end"}, bus.busy, 0);
        check({name, " sel end"}, bus.mux_sel, 0);
        tick();
        check({name, " valid pulse"}, bus.dout_valid, 0);
        check({name, " dout held"}, bus.dout, exp);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " mux_sel"}, bus.mux_sel, 0);
        check({name, " busy"}, bus.busy, 0);
        check({name, " dout"}, bus.dout, 0);
        check({name, " dout_valid"}, bus.dout_valid, 0);
        check({name, " overrun"}, bus.overrun, 0);
    endtask

    initial begin
        logic [31:0] r;
        int          seen;

        tbl[0].name = "basic";
        tbl[0].x    = '{20'sd100, 20'sd200, 20'sd300, 20'sd400};
        tbl[0].c    = '{16'sh4000, 16'sh4000, 16'sh4000, 16'sh4000};
        tbl[0].exp  = 20'sd500;
        tbl[1].name = "negative";
        tbl[1].x    = '{-20'sd100, -20'sd100, -20'sd100, -20'sd100};
        tbl[1].c    = '{16'sh4000, 16'sh4000, 16'sh4000, 16'sh4000};
        tbl[1].exp  = 20'shFFF38;
        tbl[2].name = "fullscale";
        tbl[2].x    = '{20'sh7FFFF, 20'sh7FFFF, 20'sh7FFFF, 20'sh7FFFF};
        tbl[2].c    = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
`ifdef FIR_MAC_SAT_EN
        tbl[2].exp  = 20'sh7FFFF;
`else
        tbl[2].exp  = 20'shFFFBC;
`endif
        tbl[3].name = "floor_pos";
        tbl[3].x    = '{20'sd1, 20'sd0, 20'sd0, 20'sd0};
        tbl[3].c    = '{16'sh7FFF, 16'sh0000, 16'sh0000, 16'sh0000};
        tbl[3].exp  = 20'sd0;
        tbl[4].name = "floor_neg";
        tbl[4].x    = '{-20'sd1, 20'sd0, 20'sd0, 20'sd0};
        tbl[4].c    = '{16'sh0001, 16'sh0000, 16'sh0000, 16'sh0000};
        tbl[4].exp  = -20'sd1;
        tbl[5].name = "tap_order";
        tbl[5].x    = '{-20'sd3, 20'sd5, 20'sd7, -20'sd2};
        tbl[5].c    = '{16'sh8000, 16'sh0002, -16'sd4, 16'sh4000};
        tbl[5].exp  = 20'sd1;

        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mux_in[i] = '0;
            cf[i]     = '0;
        end

        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check_reset_outputs("post-reset idle");

        for (int v = 0; v < 6; v++) begin
            mux_in = tbl[v].x;
            cf     = tbl[v].c;
            run_pass(tbl[v].name, tbl[v].exp);
        end

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = $urandom();
                mux_in[i] = r[FW-1:0];
                r = $urandom();
                cf[i] = r[CW-1:0];
                if ($urandom_range(0, 3) == 0) mux_in[i] = r[0] ? 20'sh7FFFF : 20'sh80000;
                if ($urandom_range(0, 3) == 0) cf[i] = r[1] ? 16'sh7FFF : 16'sh8000;
            end
            run_pass("random", model_result());
            repeat ($urandom_range(0, 2)) begin
                check("idle mux_sel", bus.mux_sel, 0);
                check("idle valid", bus.dout_valid, 0);
                tick();
            end
        end

        // Start held for 12 cycles: passes accepted at cycles 1, 6 and 11.
        check("overrun clear", bus.overrun, 0);
        mux_in = tbl[0].x;
        cf     = tbl[0].c;
        bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("held valid", bus.dout_valid, (i == 5 || i == 10) ? 1 : 0);
            if (i == 5 || i == 10) check("held dout", bus.dout, 500);
        end
        bus.start = 1'b0;
        check("overrun set", bus.overrun, 1);
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (bus.dout_valid === 1'b1) seen = i + 1;
        end
        check("third pass latency", seen, 3);
        check("third pass dout", bus.dout, 500);
        check("overrun sticky", bus.overrun, 1);
        repeat (2) tick();

        // Asynchronous reset during phase 2.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("mid-pass sel", bus.mux_sel, 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("aborted valid", bus.dout_valid, 0);
            check("aborted busy", bus.busy, 0);
        end
        run_pass("after reset", 20'sd500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
